// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, divider state encoding and HI/LO write selects
package cpu_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_e;
  localparam logic [1:0] HL_WSEL_NONE = 2'b00;
  localparam logic [1:0] HL_WSEL_LO   = 2'b01;
  localparam logic [1:0] HL_WSEL_HI   = 2'b10;
  localparam logic [1:0] HL_WSEL_BOTH = 2'b11;
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate, used for abs on entry and sign fix on exit
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);
  assign dout = neg ? -din : din;
endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for DIV/DIVU in the EX stage
module ex_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_start,
  input  logic             div_unsigned,
  input  logic             div_cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_stall,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  div_state_e state, state_n;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] a_raw, b_mag, rem, quo, q_hold, r_hold;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0] rem_sh, diff;
  logic neg_q, neg_r, dz, go, fin, ge;
  assign go     = state == DIV_IDLE && div_start && !div_cancel;
  assign fin    = state == DIV_FIN && !div_cancel;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, b_mag};
  assign ge     = rem_sh >= {1'b0, b_mag};
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.din(dividend), .neg(!div_unsigned && dividend[WIDTH-1]), .dout(a_abs));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.din(divisor), .neg(!div_unsigned && divisor[WIDTH-1]), .dout(b_abs));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.din(quo), .neg(neg_q), .dout(q_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.din(rem), .neg(neg_r), .dout(r_fix));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= DIV_IDLE;
    else state <= state_n;
  always_comb begin
    state_n   = div_cancel ? DIV_IDLE :
                state == DIV_IDLE ? (div_start ? DIV_CALC : DIV_IDLE) :
                state == DIV_CALC ? (count == CW'(WIDTH - 1) ? DIV_FIN : DIV_CALC) : DIV_IDLE;
    div_stall = go || state == DIV_CALC;
    div_done  = fin;
    quotient  = fin ? (dz ? '1 : q_fix) : q_hold;
    remainder = fin ? (dz ? a_raw : r_fix) : r_hold;
  end
  // quo starts as the dividend magnitude and fills with quotient bits as it shifts out
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      a_raw  <= '0;
      b_mag  <= '0;
      rem    <= '0;
      quo    <= '0;
      q_hold <= '0;
      r_hold <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      if (go) begin
        count <= '0;
        a_raw <= dividend;
        b_mag <= b_abs;
        rem   <= '0;
        quo   <= a_abs;
        neg_q <= !div_unsigned && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r <= !div_unsigned && dividend[WIDTH-1];
        dz    <= divisor == '0;
      end else if (state == DIV_CALC) begin
        rem   <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo   <= {quo[WIDTH-2:0], ge};
        count <= count + CW'(1);
      end
      if (fin) begin
        q_hold <= quotient;
        r_hold <= remainder;
      end
    end
  end
endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: scoreboard bench for ex_div_unit with directed and random DIV/DIVU ops
module tb_ex_div_unit;
  logic clk = 1'b0;
  logic resetn, div_start, div_unsigned, div_cancel;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic div_stall, div_done;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  int sb_c[$];
  ex_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .div_start(div_start), .div_unsigned(div_unsigned),
    .div_cancel(div_cancel), .dividend(dividend), .divisor(divisor),
    .div_stall(div_stall), .div_done(div_done), .quotient(quotient), .remainder(remainder)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // reference: architectural DIV/DIVU semantics including divide-by-zero and overflow rules
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic uns);
    int sa, sb;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (uns) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = a;
    sb = b;
    return {32'(sa / sb), 32'(sa % sb)};
  endfunction
  always @(negedge clk)
    if (resetn && div_done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        logic [63:0] e;
        int ec;
        e = sb_q.pop_front();
        ec = sb_c.pop_front();
        check("quotient", quotient, e[63:32]);
        check("remainder", remainder, e[31:0]);
        check("done_cycle", cyc, ec);
      end
    end
  // caller is #1 after a rising edge; leaves div_start high so a following op can go back-to-back
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic uns,
                        input logic [31:0] eq, input logic [31:0] er);
    dividend = a;
    divisor = b;
    div_unsigned = uns;
    div_start = 1'b1;
    sb_q.push_back({eq, er});
    sb_c.push_back(cyc + 33);
    for (int i = 0; ; i++) begin
      @(negedge clk);
      check("stall", {31'b0, div_stall}, {31'b0, i < 33});
      if (div_done) break;
      if (i == 40) begin
        check("timeout_done", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask
  task automatic run_model(input logic [31:0] a, input logic [31:0] b, input logic uns);
    logic [63:0] e;
    e = model(a, b, uns);
    run_op(a, b, uns, e[63:32], e[31:0]);
  endtask
  task automatic idle(input int n);
    div_start = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    resetn = 1'b0;
    div_start = 1'b0;
    div_unsigned = 1'b0;
    div_cancel = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_done", {31'b0, div_done}, 0);
    check("rst_stall", {31'b0, div_stall}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op(100, 7, 1'b1, 32'h0E, 2);
    idle(1);
    run_op(-32'sd7, 2, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    idle(1);
    run_op(7, -32'sd2, 1'b0, 32'hFFFF_FFFD, 1);
    idle(2);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 0);
    idle(1);
    run_op(32'hFFFF_FFFF, 1, 1'b1, 32'hFFFF_FFFF, 0);
    idle(1);
    run_op(5, 0, 1'b0, 32'hFFFF_FFFF, 5);
    idle(1);
    dividend = 100;
    divisor = 7;
    div_unsigned = 1'b0;
    div_start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    div_cancel = 1'b1;
    @(posedge clk); #1;
    div_cancel = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    check("cancel_stall", {31'b0, div_stall}, 0);
    check("cancel_q_hold", quotient, 32'hFFFF_FFFF);
    check("cancel_r_hold", remainder, 5);
    @(posedge clk); #1;
    idle(30);
    div_start = 1'b1;
    div_cancel = 1'b1;
    @(negedge clk);
    check("start_cancel_stall", {31'b0, div_stall}, 0);
    @(posedge clk); #1;
    div_start = 1'b0;
    div_cancel = 1'b0;
    @(negedge clk);
    check("start_cancel_idle", {31'b0, div_stall}, 0);
    @(posedge clk); #1;
    idle(35);
    run_op(1000, 10, 1'b1, 100, 0);
    run_op(-32'sd1000, 7, 1'b0, -32'sd142, -32'sd6);
    run_op(12345, 0, 1'b1, 32'hFFFF_FFFF, 12345);
    dividend = 1000;
    divisor = 3;
    div_unsigned = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    div_start = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_done", {31'b0, div_done}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op(1000, 3, 1'b1, 333, 1);
    idle(1);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, b;
      int sel;
      a = $urandom;
      sel = $urandom_range(0, 7);
      b = sel == 0 ? 32'd0 : sel == 1 ? 32'hFFFF_FFFF : sel < 5 ? $urandom_range(1, 300) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_model(a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);
    check("pending_ops", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
